// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Ports: clk, rst (sync, active-high), start/sub/a/b/cin in; busy/done/s/cout/invalid out.
// Optional: define BCD_INVALID_CHECK_EN to build the non-BCD digit detector.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, s_q;
  logic          sub_q, c_q, cout_q, done_q;
  logic [IW-1:0] idx_q;

  logic [3:0] ad, bd_raw, bd, dig;
  logic [4:0] t, tp6;
  logic       gt9, last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign last = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    s    = s_q;
    cout = cout_q;
  end

  // Select the current digit of each captured operand.
  always_comb begin
    ad     = 4'd0;
    bd_raw = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        ad     = a_q[4*i +: 4];
        bd_raw = b_q[4*i +: 4];
      end
    end
  end

  // Subtraction adds the nine's complement; the inverted borrow-in
  // seeded into c_q completes the ten's complement.
  always_comb begin
    bd  = sub_q ? (4'd9 - bd_raw) : bd_raw;
    t   = {1'b0, ad} + {1'b0, bd} + {4'd0, c_q};
    gt9 = (t > 5'd9);
    tp6 = t + 5'd6;
    dig = gt9 ? tp6[3:0] : t[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            c_q   <= sub ? ~cin : cin;
            idx_q <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) s_q[4*i +: 4] <= dig;
          end
          c_q   <= gt9;
          idx_q <= idx_q + 1'b1;
        end
        FIN: begin
          cout_q <= c_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic flag_q, inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            flag_q <= 1'b0;
            inv_q  <= 1'b0;
          end
        end
        RUN: begin
          if ((ad > 4'd9) || (bd_raw > 4'd9)) flag_q <= 1'b1;
        end
        FIN:     inv_q <= flag_q;
        default: ;
      endcase
    end
  end

  assign invalid = inv_q;
`else
  assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: vector table + scoreboard on a 2-digit
// instance, plus reset/busy corner sequences and an 8-digit instance.
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       st2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0, s2;
  logic       busy2, done2, cout2, inv2;

  logic        st8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [31:0] a8 = '0, b8 = '0, s8;
  logic        busy8, done8, cout8, inv8;

  bcd_serial_addsub #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .sub(sub2),
    .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
    .s(s2), .cout(cout2), .invalid(inv2)
  );

  bcd_serial_addsub #(.DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .s(s8), .cout(cout8), .invalid(inv8)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       sub, cin;
    logic [7:0] s;
    logic       cout, inv;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       cout, inv;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic inv_exp(input logic v);
`ifdef BCD_INVALID_CHECK_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic sub, input logic cin,
                              input logic [7:0] s, input logic cout,
                              input logic inv);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.s = s; v.cout = cout; v.inv = inv;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done2) begin
      chk("done_expected", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("s", {24'd0, s2}, {24'd0, e.s});
        chk("cout", {31'd0, cout2}, {31'd0, e.cout});
        chk("invalid", {31'd0, inv2}, {31'd0, e.inv});
      end
    end
  end

  task automatic op2(input vec_t v);
    int n;
    exp_t e;
    @(posedge clk); #1;
    a2 = v.a; b2 = v.b; sub2 = v.sub; cin2 = v.cin; st2 = 1'b1;
    e.s = v.s; e.cout = v.cout; e.inv = inv_exp(v.inv);
    sbq.push_back(e);
    @(posedge clk); #1;
    st2 = 1'b0;
    a2 = 8'($urandom); b2 = 8'($urandom);
    sub2 = 1'($urandom); cin2 = 1'($urandom);
    chk("busy_run", {31'd0, busy2}, 1);
    n = 0;
    while (!done2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency2", n, 3);
    chk("busy_at_done", {31'd0, busy2}, 0);
  endtask

  task automatic op8(input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic cin,
                     input logic [31:0] es, input logic ec);
    int n;
    @(posedge clk); #1;
    a8 = a; b8 = b; sub8 = sub; cin8 = cin; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    a8 = $urandom; b8 = $urandom;
    chk("busy8", {31'd0, busy8}, 1);
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", n, 9);
    chk("s8", s8, es);
    chk("cout8", {31'd0, cout8}, {31'd0, ec});
    chk("inv8", {31'd0, inv8}, 0);
  endtask

  initial begin
    int n;
    exp_t e;
    tbl[0]  = mk(8'h45, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[1]  = mk(8'h99, 8'h72, 1'b0, 1'b0, 8'h71, 1'b1, 1'b0);
    tbl[2]  = mk(8'h01, 8'h02, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    tbl[3]  = mk(8'h85, 8'h29, 1'b1, 1'b0, 8'h56, 1'b1, 1'b0);
    tbl[4]  = mk(8'h25, 8'h32, 1'b1, 1'b0, 8'h93, 1'b0, 1'b0);
    tbl[5]  = mk(8'h50, 8'h49, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    tbl[6]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    tbl[7]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[8]  = mk(8'h99, 8'h99, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    tbl[9]  = mk(8'h1A, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1);
    tbl[10] = mk(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_s", {24'd0, s2}, 0);
    chk("rst_cout", {31'd0, cout2}, 0);
    chk("rst_busy", {31'd0, busy2}, 0);
    chk("rst_done", {31'd0, done2}, 0);
    chk("rst_inv", {31'd0, inv2}, 0);
    chk("rst_s8", s8, 0);

    for (int i = 0; i < 11; i++) op2(tbl[i]);

    // start asserted again while busy must be dropped
    @(posedge clk); #1;
    a2 = 8'h29; b2 = 8'h02; sub2 = 1'b0; cin2 = 1'b0; st2 = 1'b1;
    e.s = 8'h31; e.cout = 1'b0; e.inv = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    a2 = 8'h65; b2 = 8'h98;
    chk("busy_prot_busy", {31'd0, busy2}, 1);
    @(posedge clk); #1;
    st2 = 1'b0;
    n = 0;
    while (!done2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_prot_lat", n, 2);
    repeat (4) @(posedge clk);
    #1 chk("busy_prot_idle", {31'd0, busy2}, 0);
    op2(mk(8'h65, 8'h98, 1'b0, 1'b0, 8'h63, 1'b1, 1'b0));

    // reset in the middle of a run aborts without done
    @(posedge clk); #1;
    a2 = 8'h99; b2 = 8'h01; sub2 = 1'b0; cin2 = 1'b0; st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_s", {24'd0, s2}, 0);
    chk("abort_cout", {31'd0, cout2}, 0);
    chk("abort_busy", {31'd0, busy2}, 0);
    repeat (5) @(posedge clk);
    #1 chk("abort_busy_later", {31'd0, busy2}, 0);
    op2(mk(8'h99, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));

    op8(32'h99999999, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
    op8(32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'h99999999, 1'b0);
    op8(32'h12345678, 32'h87654321, 1'b0, 1'b1, 32'h00000000, 1'b1);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
